// File: rtl/shift8_ctrl.sv
// rtl/shift8_ctrl.sv - 8-bit shift/rotate controller driving a 4:1-mux shifter register
// Define SHIFT8_ROTATE_EN to make op 11 rotate left; otherwise op 11 loads and reports err.
module shift8_ctrl (
  input  logic       clk,
  input  logic       reset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic [2:0] cmd_amt,
  input  logic [7:0] cmd_data,
  output logic [1:0] sel,
  output logic [7:0] q,
  output logic       busy,
  output logic       done,
  output logic       err
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  localparam logic [1:0] OP_LSL = 2'b00;
  localparam logic [1:0] OP_LSR = 2'b01;
  localparam logic [1:0] OP_ASR = 2'b10;
  localparam logic [1:0] OP_ROL = 2'b11;

  localparam logic [1:0] SEL_HOLD  = 2'b00;
  localparam logic [1:0] SEL_LOAD  = 2'b01;
  localparam logic [1:0] SEL_LEFT  = 2'b10;
  localparam logic [1:0] SEL_RIGHT = 2'b11;

  state_t     state, state_nxt;
  logic [1:0] op_r;
  logic [2:0] cnt;
  logic [7:0] q_shift;
  logic       accept;
  logic       rol_reject;

  assign cmd_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);
  // Reset wins over an accept in the same cycle, so sel never shows LOAD then.
  assign accept    = cmd_valid && cmd_ready && !reset;

`ifdef SHIFT8_ROTATE_EN
  assign rol_reject = 1'b0;
  assign err        = 1'b0;
`else
  logic err_r;
  assign rol_reject = (cmd_op == OP_ROL);
  assign err        = done && err_r;
`endif

  always_comb begin
    state_nxt = state;
    sel       = SEL_HOLD;
    case (state)
      IDLE: begin
        if (accept) begin
          sel = SEL_LOAD;
          if (rol_reject || cmd_amt == 3'd0) state_nxt = DONE;
          else                               state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        sel = (op_r == OP_LSR || op_r == OP_ASR) ? SEL_RIGHT : SEL_LEFT;
        if (cnt == 3'd1) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    q_shift = q;
    case (op_r)
      OP_LSL:  q_shift = {q[6:0], 1'b0};
      OP_LSR:  q_shift = {1'b0, q[7:1]};
      OP_ASR:  q_shift = {q[7], q[7:1]};
      OP_ROL:  q_shift = {q[6:0], q[7]};
      default: q_shift = q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      q     <= 8'h00;
      op_r  <= OP_LSL;
      cnt   <= 3'd0;
`ifndef SHIFT8_ROTATE_EN
      err_r <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      case (sel)
        SEL_LOAD: begin
          q    <= cmd_data;
          op_r <= cmd_op;
          cnt  <= cmd_amt;
`ifndef SHIFT8_ROTATE_EN
          err_r <= rol_reject;
`endif
        end
        SEL_LEFT, SEL_RIGHT: begin
          q   <= q_shift;
          cnt <= cnt - 3'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_shift8_ctrl.sv
// tb/tb_shift8_ctrl.sv - directed self-checking bench for shift8_ctrl
module tb_shift8_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [2:0] cmd_amt;
  logic [7:0] cmd_data;
  logic [1:0] sel;
  logic [7:0] q;
  logic       busy;
  logic       done;
  logic       err;

  int checks = 0;
  int errors = 0;

  shift8_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_amt   (cmd_amt),
    .cmd_data  (cmd_data),
    .sel       (sel),
    .q         (q),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input string tag, input logic [7:0] exp_q);
    check({tag, "_q"}, 16'(q), 16'(exp_q));
    check({tag, "_ready"}, 16'(cmd_ready), 16'd1);
    check({tag, "_done"}, 16'(done), 16'd0);
    check({tag, "_sel"}, 16'(sel), 16'd0);
    check({tag, "_busy"}, 16'(busy), 16'd0);
  endtask

  // Entered and left just after a rising edge; command inputs are scrambled while busy.
  task automatic run_cmd(input string tag, input logic [1:0] op, input logic [2:0] amt,
                         input logic [7:0] data, input int n_shift, input logic [1:0] exp_sel,
                         input logic [7:0] exp_q, input logic exp_err);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_amt   = amt;
    cmd_data  = data;
    @(negedge clk);
    check({tag, "_acc_ready"}, 16'(cmd_ready), 16'd1);
    check({tag, "_acc_sel"}, 16'(sel), 16'd1);
    @(posedge clk); #1;
    cmd_op   = op ^ 2'b01;
    cmd_amt  = amt ^ 3'b101;
    cmd_data = ~data;
    for (int i = 0; i < n_shift; i++) begin
      @(negedge clk);
      check({tag, "_shift_sel"}, 16'(sel), 16'(exp_sel));
      check({tag, "_shift_done"}, 16'(done), 16'd0);
      check({tag, "_shift_busy"}, 16'(busy), 16'd1);
      @(posedge clk); #1;
    end
    @(negedge clk);
    check({tag, "_done"}, 16'(done), 16'd1);
    check({tag, "_err"}, 16'(err), 16'(exp_err));
    check({tag, "_q"}, 16'(q), 16'(exp_q));
    check({tag, "_done_sel"}, 16'(sel), 16'd0);
    check({tag, "_done_ready"}, 16'(cmd_ready), 16'd0);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    @(negedge clk);
    check_idle({tag, "_after"}, exp_q);
    check({tag, "_after_err"}, 16'(err), 16'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    reset     = 1'b1;
    cmd_valid = 1'b0;
    cmd_op    = 2'b00;
    cmd_amt   = 3'd0;
    cmd_data  = 8'h00;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_idle("reset_idle", 8'h00);
      check("reset_idle_err", 16'(err), 16'd0);
    end
    @(posedge clk); #1;

    run_cmd("lsl_81_3", 2'b00, 3'd3, 8'h81, 3, 2'b10, 8'h08, 1'b0);
    run_cmd("asr_90_2", 2'b10, 3'd2, 8'h90, 2, 2'b11, 8'hE4, 1'b0);
    run_cmd("lsr_90_2", 2'b01, 3'd2, 8'h90, 2, 2'b11, 8'h24, 1'b0);
    run_cmd("amt0_5a",  2'b00, 3'd0, 8'h5A, 0, 2'b00, 8'h5A, 1'b0);
    run_cmd("lsr_80_7", 2'b01, 3'd7, 8'h80, 7, 2'b11, 8'h01, 1'b0);
`ifdef SHIFT8_ROTATE_EN
    run_cmd("rol_81_1", 2'b11, 3'd1, 8'h81, 1, 2'b10, 8'h03, 1'b0);
    run_cmd("rol_c3_4", 2'b11, 3'd4, 8'hC3, 4, 2'b10, 8'h3C, 1'b0);
`else
    run_cmd("rol_81_1", 2'b11, 3'd1, 8'h81, 0, 2'b00, 8'h81, 1'b1);
    run_cmd("rol_c3_4", 2'b11, 3'd4, 8'hC3, 0, 2'b00, 8'hC3, 1'b1);
`endif

    // Reset during the second SHIFT cycle of a 7-step command.
    cmd_valid = 1'b1;
    cmd_op    = 2'b00;
    cmd_amt   = 3'd7;
    cmd_data  = 8'hFF;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    check("midshift_busy", 16'(busy), 16'd1);
    @(posedge clk); #1;
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_idle("abort_idle", 8'h00);
    end
    @(posedge clk); #1;

    // Reset coinciding with a valid command must win.
    reset     = 1'b1;
    cmd_valid = 1'b1;
    cmd_data  = 8'hA5;
    cmd_amt   = 3'd0;
    @(negedge clk);
    check("rst_vs_acc_sel", 16'(sel), 16'd0);
    @(posedge clk); #1;
    reset     = 1'b0;
    cmd_valid = 1'b0;
    @(negedge clk);
    check_idle("rst_vs_acc", 8'h00);
    @(posedge clk); #1;

    run_cmd("post_rst_asr_80_7", 2'b10, 3'd7, 8'h80, 7, 2'b11, 8'hFF, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/shift8_ctrl.md
SHIFT8_CTRL -- requirements
Module: shift8_ctrl

Interface
REQ-001 The block SHALL have no parameters; data width is fixed at 8 bits and shift amount at 3 bits.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 cmd_valid  input  1  command request.
REQ-005 cmd_ready  output  1  high when a command can be accepted.
REQ-006 cmd_op  input  2  operation: 00 LSL, 01 LSR, 10 ASR, 11 ROL.
REQ-007 cmd_amt  input  3  shift amount, 0..7 single-bit steps.
REQ-008 cmd_data  input  8  operand to load.
REQ-009 sel  output  2  per-bit 4:1 mux select driven to the shifter register: 00 hold, 01 load, 10 shift left, 11 shift right.
REQ-010 q  output  8  shifter register contents.
REQ-011 busy  output  1  high in LOAD-free states SHIFT and DONE.
REQ-012 done  output  1  one-cycle completion pulse.
REQ-013 err  output  1  one-cycle error pulse, coincident with done.

Function
REQ-014 States SHALL be IDLE, SHIFT, DONE; cmd_ready SHALL be 1 only in IDLE.
REQ-015 Accept occurs in a cycle where cmd_valid=1 and cmd_ready=1; at that edge q<=cmd_data, op and cnt<=cmd_amt are latched, and sel SHALL read 01 during the accept cycle.
REQ-016 After accept, next state SHALL be SHIFT if cmd_amt!=0, else DONE.
REQ-017 In SHIFT each edge SHALL perform one 1-bit shift and decrement cnt; on the edge where cnt==1 the state SHALL go to DONE.
REQ-018 LSL: q<={q[6:0],0}, sel=10. LSR: q<={0,q[7:1]}, sel=11. ASR: q<={q[7],q[7:1]}, sel=11. ROL: q<={q[6:0],q[7]}, sel=10.
REQ-019 In IDLE (no accept) and DONE, sel SHALL be 00 and q SHALL hold.
REQ-020 done SHALL be 1 exactly in the DONE cycle, i.e. cycle N+1+amt for accept in cycle N; DONE SHALL always return to IDLE next edge.
REQ-021 cmd_valid and cmd_* changes while busy SHALL be ignored; the latched command SHALL not be affected.
REQ-022 q SHALL hold its final value after DONE until the next accept.
REQ-023 A command accepted with cmd_valid held high SHALL be followed by the next accept no earlier than the cycle after DONE (back-to-back gap of one IDLE cycle).

Reset
REQ-024 With reset=1 at a clock edge, state SHALL become IDLE, q=8'h00, cnt=0, done=0, err=0, busy=0, sel=00; cmd_ready SHALL be 1 the cycle after.
REQ-025 Reset mid-SHIFT or in DONE SHALL abort the operation without emitting done; reset SHALL dominate a simultaneous accept.

Configuration
REQ-026 Macro SHIFT8_ROTATE_EN SHALL control op 11.
REQ-027 With SHIFT8_ROTATE_EN defined, op 11 SHALL rotate left per REQ-018 and err SHALL be constant 0.
REQ-028 Without it, op 11 SHALL be accepted, load cmd_data, skip SHIFT regardless of cmd_amt, and pulse done=1 with err=1 in cycle N+1.

Verification
REQ-029 Reset then idle: q=00, cmd_ready=1, done=0, sel=00 on every cycle.
REQ-030 LSL data=8'h81 amt=3 accepted cycle N -> q=8'h08 and done=1 in cycle N+4, sel=10 during cycles N+1..N+3.
REQ-031 ASR data=8'h90 amt=2 -> q=8'hE4 with done; LSR same operands -> q=8'h24.
REQ-032 amt=0, data=8'h5A -> done in cycle N+1, q=8'h5A, sel never 10/11.
REQ-033 ROL data=8'h81 amt=1 -> q=8'h03, err=0 (with macro); without macro -> q=8'h81, done=1 and err=1 in cycle N+1.
REQ-034 Reset asserted in second SHIFT cycle of amt=7 command -> q=00 next cycle, no done pulse, new command accepted after reset released.
